// File: rtl/varwidth_fifo_with_pre_pkg.sv
// Shared types and helpers for the pre-trigger capture buffer.
// Sample/byte widths, capture states and the N/D clamping rule.
package varwidth_fifo_with_pre_pkg;

  localparam int SAMPLE_W = 10;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    PRE  = 2'd0,
    POST = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] d;
  } nd_t;

  // N is forced into [1, max_n]; D is then forced into [0, N-1].
  function automatic nd_t clamp_nd(input logic [31:0] num, input logic [31:0] depth,
                                   input logic [31:0] max_n);
    nd_t r;
    r.n = (num == 32'd0) ? 32'd1 : ((num > max_n) ? max_n : num);
    r.d = (depth > r.n - 32'd1) ? r.n - 32'd1 : depth;
    return r;
  endfunction

endpackage

// File: rtl/varwidth_fifo_with_pre_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Contents are intentionally not reset.
module sample_ram
  import varwidth_fifo_with_pre_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int AW    = 7
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/varwidth_fifo_with_pre.sv
// Pre-trigger capture buffer: ring of D samples before the trigger, linear fill
// after it, then oldest-first readout repacked from 10-bit samples into bytes.
module varwidth_fifo_with_pre
  import varwidth_fifo_with_pre_pkg::*;
#(
  parameter int max_samples = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         number_samples,
  input  logic [31:0]         wr_circular_depth,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                wr_ce,
  input  logic                wr_trigger,
  output logic                wr_done,
  output logic [BYTE_W-1:0]   rd_data,
  input  logic                rd_ce
);

  localparam int AW    = $clog2(max_samples);
  localparam int CW    = AW + 1;
  localparam int RW    = AW + 2;
  localparam int ACC_W = 2 * SAMPLE_W - 3;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, start_q, start_d;
  logic [AW-1:0]       ptr_eff, ram_waddr, ram_raddr;
  logic [CW-1:0]       fill_q, fill_d, n_q, n_d, d_q, d_d;
  logic [CW-1:0]       post_cnt_q, post_cnt_d, pre_q, pre_d, sidx_q, sidx_d;
  logic [CW-1:0]       n_cur, d_cur, ptr_next, post_addr, lin_addr, rec_cnt;
  logic [RW-1:0]       ring_sum;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_shr;
  logic [4:0]          cnt_q, cnt_d, cnt_use, cnt_left;
  logic                primed_q, primed_d, wr_done_q, wr_done_d;
  logic                ram_we, load;
  logic [SAMPLE_W-1:0] ram_rdata;
  logic [BYTE_W-1:0]   byte_hi, byte_lo;
  nd_t                 nd_cur;
  logic                unused_hi;

  assign nd_cur    = clamp_nd(number_samples, wr_circular_depth, 32'(max_samples));
  assign n_cur     = nd_cur.n[CW-1:0];
  assign d_cur     = nd_cur.d[CW-1:0];
  // A pointer left beyond a shrunken ring restarts at slot 0.
  assign ptr_eff   = ({1'b0, wr_ptr_q} < d_cur) ? wr_ptr_q : '0;
  assign ptr_next  = {1'b0, ptr_eff} + CW'(1);
  assign post_addr = d_q + post_cnt_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    n_d        = n_q;
    d_d        = d_q;
    post_cnt_d = post_cnt_q;
    pre_d      = pre_q;
    start_d    = start_q;
    ram_we     = 1'b0;
    ram_waddr  = '0;
    case (state_q)
      PRE: begin
        if (wr_trigger) begin
          n_d     = n_cur;
          d_d     = d_cur;
          state_d = POST;
          if (fill_q >= d_cur) begin
            pre_d   = d_cur;
            start_d = ptr_eff;
          end else begin
            pre_d   = fill_q;
            start_d = '0;
          end
          if (wr_ce) begin
            ram_we     = 1'b1;
            ram_waddr  = d_cur[AW-1:0];
            post_cnt_d = CW'(1);
            if (n_cur - d_cur == CW'(1)) state_d = DONE;
          end
        end else if (wr_ce && d_cur != '0) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_eff;
          wr_ptr_d  = (ptr_next == d_cur) ? '0 : ptr_next[AW-1:0];
          fill_d    = (fill_q >= d_cur) ? d_cur : fill_q + CW'(1);
        end
      end
      POST: begin
        if (wr_ce) begin
          ram_we     = 1'b1;
          ram_waddr  = post_addr[AW-1:0];
          post_cnt_d = post_cnt_q + CW'(1);
          if (post_cnt_d == n_q - d_q) state_d = DONE;
        end
      end
      default: ;
    endcase
  end

  // Repacker: acc holds cnt valid bits right-aligned, oldest bit highest.
  assign rec_cnt = pre_q + (n_q - d_q);

  always_comb begin
    cnt_use = '0;
    if (wr_done_q && rd_ce) cnt_use = (cnt_q >= 5'd8) ? 5'd8 : cnt_q;
    cnt_left  = cnt_q - cnt_use;
    load      = primed_q && (state_q == DONE) && (cnt_left < 5'd8) && (sidx_q < rec_cnt);
    acc_d     = load ? {acc_q[ACC_W-SAMPLE_W-1:0], ram_rdata} : acc_q;
    cnt_d     = load ? cnt_left + 5'd10 : cnt_left;
    sidx_d    = load ? sidx_q + CW'(1) : sidx_q;
    primed_d  = (state_q == DONE);
    wr_done_d = wr_done_q | (primed_q & (state_q == DONE));
  end

  // The RAM is addressed with the next sample index so its registered output
  // always holds sample sidx_q, giving a one-sample prefetch.
  always_comb begin
    ring_sum = RW'(start_q) + RW'(sidx_d);
    if (ring_sum >= RW'(d_q)) ring_sum = ring_sum - RW'(d_q);
    lin_addr  = d_q + (sidx_d - pre_q);
    ram_raddr = (sidx_d < pre_q) ? ring_sum[AW-1:0] : lin_addr[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRE;
      wr_ptr_q   <= '0;
      start_q    <= '0;
      fill_q     <= '0;
      n_q        <= '0;
      d_q        <= '0;
      post_cnt_q <= '0;
      pre_q      <= '0;
      sidx_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      start_q    <= start_d;
      fill_q     <= fill_d;
      n_q        <= n_d;
      d_q        <= d_d;
      post_cnt_q <= post_cnt_d;
      pre_q      <= pre_d;
      sidx_q     <= sidx_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      wr_done_q  <= wr_done_d;
    end
  end

  sample_ram #(
    .DEPTH(max_samples),
    .AW   (AW)
  ) u_sample_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(wr_data),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Full byte from the top of the accumulator, or the zero-padded tail.
  assign acc_shr = acc_q >> (cnt_q - 5'd8);
  assign byte_hi = acc_shr[BYTE_W-1:0];
  assign byte_lo = acc_q[BYTE_W-1:0] << (5'd8 - cnt_q);
  assign rd_data = !wr_done_q ? '0 : ((cnt_q >= 5'd8) ? byte_hi : byte_lo);
  assign wr_done = wr_done_q;

  assign unused_hi = ^{nd_cur.n[31:CW], nd_cur.d[31:CW], post_addr[CW-1:AW],
                       lin_addr[CW-1:AW], acc_shr[ACC_W-1:BYTE_W]};

endmodule

// File: tb/tb_varwidth_fifo_with_pre.sv
// Directed bench for the pre-trigger capture buffer: builds the expected record
// from the stimulus and compares the byte stream and wr_done timing.
module tb_varwidth_fifo_with_pre;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] number_samples = 32'd0;
  logic [31:0] wr_circular_depth = 32'd0;
  logic [9:0]  wr_data = 10'd0;
  logic        wr_ce = 1'b0;
  logic        wr_trigger = 1'b0;
  logic        wr_done;
  logic [7:0]  rd_data;
  logic        rd_ce = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int final_cyc = -1;
  int rec[$];
  logic [7:0] got[$];

  varwidth_fifo_with_pre #(.max_samples(100)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .number_samples   (number_samples),
    .wr_circular_depth(wr_circular_depth),
    .wr_data          (wr_data),
    .wr_ce            (wr_ce),
    .wr_trigger       (wr_trigger),
    .wr_done          (wr_done),
    .rd_data          (rd_data),
    .rd_ce            (rd_ce)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit hit, required normal finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; also checks wr_done rises exactly two edges after the final store.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (final_cyc >= 0) begin
      if (cyc - final_cyc < 2) check_val("done_early", 32'(wr_done), 32'd0);
      else if (cyc - final_cyc == 2) check_val("done_rise", 32'(wr_done), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_ce = 1'b0;
    wr_trigger = 1'b0;
    rd_ce = 1'b0;
    final_cyc = -1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic capture(input int n, input int d, input int pre_n, input int pre_base,
                         input bit trig_ce, input int trig_val, input int post_base,
                         input int post_n, input bit noisy);
    int ne, de, keep, need, have;
    int hist[$];
    ne = (n < 1) ? 1 : ((n > 100) ? 100 : n);
    de = (d > ne - 1) ? ne - 1 : d;
    rec.delete();
    final_cyc = -1;
    number_samples = 32'(n);
    wr_circular_depth = 32'(d);
    for (int i = 0; i < pre_n; i++) begin
      wr_ce = 1'b1;
      wr_data = 10'((pre_base + i) % 1024);
      hist.push_back((pre_base + i) % 1024);
      step();
    end
    keep = (pre_n < de) ? pre_n : de;
    for (int i = hist.size() - keep; i < hist.size(); i++) rec.push_back(hist[i]);
    need = ne - de;
    have = 0;
    wr_trigger = 1'b1;
    wr_ce = trig_ce;
    wr_data = 10'(trig_val);
    if (trig_ce) begin
      rec.push_back(trig_val);
      have = 1;
      if (have == need) final_cyc = cyc + 1;
    end
    step();
    wr_trigger = noisy;
    if (noisy) begin
      number_samples = 32'd3;
      wr_circular_depth = 32'd1;
    end
    for (int i = 0; i < post_n; i++) begin
      int v;
      v = (post_base + i) % 1024;
      wr_ce = 1'b1;
      wr_data = 10'(v);
      rd_ce = noisy && (have < need);
      if (have < need) begin
        rec.push_back(v);
        have++;
        if (have == need) final_cyc = cyc + 1;
      end
      step();
    end
    wr_ce = 1'b0;
    wr_trigger = 1'b0;
    rd_ce = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_val("done_hold", 32'(wr_done), 32'd1);
    $display("capture N=%0d D=%0d pre_written=%0d record=%0d samples", ne, de, pre_n, rec.size());
  endtask

  task automatic readout(input int nb, input bit gap);
    int bits[$];
    int nbytes;
    logic [7:0] eb;
    got.delete();
    foreach (rec[i]) for (int b = 9; b >= 0; b--) bits.push_back((rec[i] >> b) & 1);
    nbytes = (bits.size() + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      eb = 8'h00;
      if (k < nbytes) begin
        for (int j = 0; j < 8; j++) begin
          if (8 * k + j < bits.size()) eb = {eb[6:0], 1'(bits[8 * k + j])};
          else eb = {eb[6:0], 1'b0};
        end
      end
      got.push_back(rd_data);
      check_val($sformatf("byte%0d", k), 32'(rd_data), 32'(eb));
      if (gap) begin
        rd_ce = 1'b0;
        step();
        check_val($sformatf("hold%0d", k), 32'(rd_data), 32'(eb));
      end
      rd_ce = 1'b1;
      step();
      rd_ce = 1'b0;
    end
    $display("readout %0d bytes (record has %0d bytes)", nb, nbytes);
  endtask

  initial begin
    do_reset();
    check_val("rst_done", 32'(wr_done), 32'd0);
    check_val("rst_rd", 32'(rd_data), 32'd0);

    // Main scenario: 46 pre samples into a 17-deep ring, trigger carries a sample.
    capture(100, 17, 46, 234, 1'b1, 289, 234, 100, 1'b0);
    readout(130, 1'b0);
    check_val("hand_b0", 32'(got[0]), 32'h41);
    check_val("hand_b1", 32'(got[1]), 32'hD0);
    check_val("hand_b124", 32'(got[124]), 32'h3B);
    check_val("hand_b125", 32'(got[125]), 32'h00);
    check_val("hand_b129", 32'(got[129]), 32'h00);

    // Ring only partly filled; retrigger and rd_ce during POST; config changes after trigger.
    do_reset();
    capture(100, 17, 5, 600, 1'b1, 'h2AA, 700, 90, 1'b1);
    readout(112, 1'b1);
    check_val("part_b110", 32'(got[110]), 32'h00);

    // D = 0: record begins with the trigger sample; then reset mid-readout.
    do_reset();
    capture(40, 0, 10, 1, 1'b1, 'h155, 900, 45, 1'b0);
    readout(20, 1'b0);
    check_val("d0_b0", 32'(got[0]), 32'h55);
    check_val("b20_pre_rst", 32'(rd_data), 32'hE4);
    check_val("done_pre_rst", 32'(wr_done), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_rd_done", 32'(wr_done), 32'd0);
    check_val("rst_rd_data", 32'(rd_data), 32'd0);

    // D = 200 clamps to 99: 99 pre samples plus the trigger sample.
    do_reset();
    capture(100, 200, 120, 500, 1'b1, 7, 0, 3, 1'b0);
    readout(126, 1'b0);
    check_val("dmax_b0", 32'(got[0]), 32'h82);
    check_val("dmax_b124", 32'(got[124]), 32'h07);

    // Trigger with wr_ce low: next write (0x3FF) is the first post sample.
    do_reset();
    capture(20, 4, 9, 100, 1'b0, 0, 1023, 30, 1'b1);
    readout(27, 1'b1);
    check_val("trig_lo_b5", 32'(got[5]), 32'hFF);

    // Reset in the middle of POST, then a fresh capture.
    do_reset();
    number_samples = 32'd50;
    wr_circular_depth = 32'd10;
    for (int i = 0; i < 20; i++) begin
      wr_ce = 1'b1;
      wr_data = 10'(i + 40);
      step();
    end
    wr_trigger = 1'b1;
    wr_data = 10'd1;
    step();
    wr_trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_data = 10'(i + 60);
      step();
    end
    wr_ce = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_post_done", 32'(wr_done), 32'd0);
    check_val("rst_post_rd", 32'(rd_data), 32'd0);
    do_reset();
    capture(30, 6, 8, 300, 1'b1, 5, 310, 30, 1'b0);
    readout(40, 1'b0);
    check_val("fresh_b37", 32'(got[37]), 32'hC0);
    check_val("fresh_b38", 32'(got[38]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
